// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch
// Brief    : Instruction fetch stage: owns the PC, issues one 32-bit read at a
//            time and buffers one instruction behind a valid/ready handshake.
//            Optional macro IFU_MISALIGN_CHECK_EN turns misaligned redirects
//            into a buffered fault entry instead of a fetch.
// Revision : 1.0
// ============================================================================
module ifu_fetch #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000000080000000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [31:0]     mem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_out,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_req_pc;
    logic              r_drop;
    logic              r_inst_valid;
    logic [31:0]       r_inst_out;
    logic [XLEN-1:0]   r_inst_pc;
    logic [XLEN-1:0]   w_redir_pc;
    logic              w_stall;
    logic              w_req_valid;
    logic              w_req_fire;
    logic              w_rsp_fire;
    logic              w_consume;

`ifdef IFU_MISALIGN_CHECK_EN
    logic              r_inst_fault;
    logic              r_fault_pend;

    assign w_redir_pc = redirect_pc;
    // A misaligned PC can only come from a redirect and is held until the next one.
    assign w_stall    = (r_pc[1:0] != 2'b00);
    assign inst_fault = r_inst_fault;
`else
    localparam logic [XLEN-1:0] c_align_mask = {{(XLEN-2){1'b1}}, 2'b00};

    assign w_redir_pc = redirect_pc & c_align_mask;
    assign w_stall    = 1'b0;
    assign inst_fault = 1'b0;
`endif

    always_comb begin
        w_req_valid = (r_state == IDLE) && !rst && !redirect_valid &&
                      (!r_inst_valid || inst_ready) && !w_stall;
        w_req_fire  = w_req_valid && mem_req_ready;
        w_rsp_fire  = (r_state == WAIT) && mem_rsp_valid;
        w_consume   = r_inst_valid && inst_ready;
    end

    assign mem_req_valid = w_req_valid;
    assign mem_req_addr  = r_pc;
    assign inst_valid    = r_inst_valid;
    assign inst_out      = r_inst_out;
    assign inst_pc       = r_inst_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_req_fire)    w_state_nxt = WAIT;
            WAIT:    if (mem_rsp_valid) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_req_pc     <= '0;
            r_drop       <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst_out   <= '0;
            r_inst_pc    <= '0;
`ifdef IFU_MISALIGN_CHECK_EN
            r_inst_fault <= 1'b0;
            r_fault_pend <= 1'b0;
`endif
        end else begin
            if (w_req_fire) begin
                r_req_pc <= r_pc;
            end
            if (redirect_valid) begin
                r_pc         <= w_redir_pc;
                r_inst_valid <= 1'b0;
                // A response landing with the redirect is discarded here, so nothing stays stale.
                r_drop       <= ((r_state == WAIT) && !mem_rsp_valid) || w_req_fire;
`ifdef IFU_MISALIGN_CHECK_EN
                r_inst_fault <= 1'b0;
                r_fault_pend <= (redirect_pc[1:0] != 2'b00);
`endif
            end else begin
                if (w_consume) begin
                    r_inst_valid <= 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
                    r_inst_fault <= 1'b0;
`endif
                end
                if (w_rsp_fire) begin
                    if (r_drop) begin
                        r_drop <= 1'b0;
                    end else begin
                        r_inst_valid <= 1'b1;
                        r_inst_out   <= mem_rsp_data;
                        r_inst_pc    <= r_req_pc;
                        r_pc         <= r_req_pc + XLEN'(4);
`ifdef IFU_MISALIGN_CHECK_EN
                        r_inst_fault <= 1'b0;
`endif
                    end
                end
`ifdef IFU_MISALIGN_CHECK_EN
                if (r_fault_pend) begin
                    r_fault_pend <= 1'b0;
                    r_inst_valid <= 1'b1;
                    r_inst_fault <= 1'b1;
                    r_inst_out   <= '0;
                    r_inst_pc    <= r_pc;
                end
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fetch
// Brief    : Directed self-checking bench for ifu_fetch (hand-computed values).
// Revision : 1.0
// ============================================================================
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [63:0] inst_pc;
    logic        inst_fault;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int n_cmp = 0;
    int n_bad = 0;

    ifu_fetch #(
        .XLEN     (64),
        .RESET_PC (64'h0000000080000000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = 32'h0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        tick();
        tick();

        // Reset state; rst alone must hold the request off
        mem_req_ready = 1'b1;
        inst_ready    = 1'b1;
        settle();
        chk("rst_req_valid", {63'b0, mem_req_valid}, 64'd0);
        chk("rst_inst_valid", {63'b0, inst_valid}, 64'd0);
        chk("rst_inst_out", {32'b0, inst_out}, 64'd0);
        chk("rst_inst_pc", inst_pc, 64'd0);
        chk("rst_inst_fault", {63'b0, inst_fault}, 64'd0);
        chk("rst_addr", mem_req_addr, 64'h80000000);

        // First fetch, 1-cycle memory
        rst = 1'b0;
        settle();
        chk("c1_req_valid", {63'b0, mem_req_valid}, 64'd1);
        chk("c1_addr", mem_req_addr, 64'h80000000);
        tick();
        chk("c2_wait_no_req", {63'b0, mem_req_valid}, 64'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h00000013;
        tick();
        mem_rsp_valid = 1'b0;
        settle();
        chk("c3_inst_valid", {63'b0, inst_valid}, 64'd1);
        chk("c3_inst_out", {32'b0, inst_out}, 64'h13);
        chk("c3_inst_pc", inst_pc, 64'h80000000);
        chk("c3_next_req", {63'b0, mem_req_valid}, 64'd1);
        chk("c3_next_addr", mem_req_addr, 64'h80000004);

        // Downstream backpressure for 5 cycles
        inst_ready = 1'b0;
        settle();
        for (int i = 0; i < 5; i++) begin
            chk("bp_req_valid", {63'b0, mem_req_valid}, 64'd0);
            chk("bp_inst_out", {32'b0, inst_out}, 64'h13);
            chk("bp_inst_pc", inst_pc, 64'h80000000);
            tick();
        end
        inst_ready = 1'b1;
        settle();
        chk("bp_release_req", {63'b0, mem_req_valid}, 64'd1);
        chk("bp_release_addr", mem_req_addr, 64'h80000004);
        tick();
        chk("bp_consumed", {63'b0, inst_valid}, 64'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h00100093;
        tick();
        mem_rsp_valid = 1'b0;
        settle();
        chk("f2_inst_out", {32'b0, inst_out}, 64'h00100093);
        chk("f2_inst_pc", inst_pc, 64'h80000004);
        chk("f2_next_addr", mem_req_addr, 64'h80000008);

        // Redirect while WAIT, stale response two cycles later
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h80001000;
        settle();
        chk("rw_req_valid", {63'b0, mem_req_valid}, 64'd0);
        tick();
        redirect_valid = 1'b0;
        settle();
        chk("rw_still_wait", {63'b0, mem_req_valid}, 64'd0);
        chk("rw_pc", mem_req_addr, 64'h80001000);
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEADBEEF;
        tick();
        mem_rsp_valid = 1'b0;
        settle();
        chk("rw_stale_dropped", {63'b0, inst_valid}, 64'd0);
        chk("rw_refetch_req", {63'b0, mem_req_valid}, 64'd1);
        chk("rw_refetch_addr", mem_req_addr, 64'h80001000);
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h11111111;
        tick();
        mem_rsp_valid = 1'b0;
        settle();
        chk("rw_inst_valid", {63'b0, inst_valid}, 64'd1);
        chk("rw_inst_out", {32'b0, inst_out}, 64'h11111111);
        chk("rw_inst_pc", inst_pc, 64'h80001000);

        // Redirect and response in the same cycle
        tick();
        mem_rsp_valid  = 1'b1;
        mem_rsp_data   = 32'h22222222;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h80002000;
        tick();
        mem_rsp_valid  = 1'b0;
        redirect_valid = 1'b0;
        settle();
        chk("rr_inst_valid", {63'b0, inst_valid}, 64'd0);
        chk("rr_req_valid", {63'b0, mem_req_valid}, 64'd1);
        chk("rr_addr", mem_req_addr, 64'h80002000);
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h33333333;
        tick();
        mem_rsp_valid = 1'b0;
        settle();
        chk("rr_no_drop_valid", {63'b0, inst_valid}, 64'd1);
        chk("rr_no_drop_out", {32'b0, inst_out}, 64'h33333333);
        chk("rr_no_drop_pc", inst_pc, 64'h80002000);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFFFFFFFFFFFFFC;
        settle();
        chk("wr_redir_no_req", {63'b0, mem_req_valid}, 64'd0);
        tick();
        redirect_valid = 1'b0;
        settle();
        chk("wr_addr", mem_req_addr, 64'hFFFFFFFFFFFFFFFC);
        chk("wr_req_valid", {63'b0, mem_req_valid}, 64'd1);
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h44444444;
        tick();
        mem_rsp_valid = 1'b0;
        settle();
        chk("wr_inst_pc", inst_pc, 64'hFFFFFFFFFFFFFFFC);
        chk("wr_inst_out", {32'b0, inst_out}, 64'h44444444);
        chk("wr_next_addr", mem_req_addr, 64'h0);

        // Spurious response while IDLE is ignored
        inst_ready    = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h55555555;
        tick();
        mem_rsp_valid = 1'b0;
        inst_ready    = 1'b1;
        settle();
        chk("sp_inst_out", {32'b0, inst_out}, 64'h44444444);
        chk("sp_inst_valid", {63'b0, inst_valid}, 64'd1);
        chk("sp_addr", mem_req_addr, 64'h0);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 64'h80000002;
        tick();
        redirect_valid = 1'b0;
        settle();
`ifdef IFU_MISALIGN_CHECK_EN
        chk("ma_req_valid", {63'b0, mem_req_valid}, 64'd0);
        chk("ma_cleared", {63'b0, inst_valid}, 64'd0);
        tick();
        chk("ma_req_valid2", {63'b0, mem_req_valid}, 64'd0);
        chk("ma_inst_valid", {63'b0, inst_valid}, 64'd1);
        chk("ma_inst_fault", {63'b0, inst_fault}, 64'd1);
        chk("ma_inst_pc", inst_pc, 64'h80000002);
        chk("ma_inst_out", {32'b0, inst_out}, 64'h0);
        tick();
        chk("ma_consumed", {63'b0, inst_valid}, 64'd0);
        chk("ma_fault_clr", {63'b0, inst_fault}, 64'd0);
        chk("ma_stalled", {63'b0, mem_req_valid}, 64'd0);
`else
        chk("ma_addr_aligned", mem_req_addr, 64'h80000000);
        chk("ma_req_valid", {63'b0, mem_req_valid}, 64'd1);
        chk("ma_inst_valid", {63'b0, inst_valid}, 64'd0);
        chk("ma_inst_fault", {63'b0, inst_fault}, 64'd0);
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h66666666;
        tick();
        mem_rsp_valid = 1'b0;
        settle();
        chk("ma_fetch_pc", inst_pc, 64'h80000000);
        chk("ma_fetch_out", {32'b0, inst_out}, 64'h66666666);
`endif

        // Reset mid-transaction; late response after reset is ignored
        redirect_valid = 1'b1;
        redirect_pc    = 64'h80003000;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("mr_in_wait", {63'b0, mem_req_valid}, 64'd0);
        rst = 1'b1;
        tick();
        settle();
        chk("mr_rst_req", {63'b0, mem_req_valid}, 64'd0);
        chk("mr_rst_addr", mem_req_addr, 64'h80000000);
        chk("mr_rst_inst_valid", {63'b0, inst_valid}, 64'd0);
        rst           = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h77777777;
        settle();
        chk("mr_req_after", {63'b0, mem_req_valid}, 64'd1);
        tick();
        mem_rsp_valid = 1'b0;
        settle();
        chk("mr_late_ignored", {63'b0, inst_valid}, 64'd0);
        chk("mr_out_zero", {32'b0, inst_out}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage sitting directly upstream of the single-cycle execute/decode logic.
- Owns the architectural PC and issues 32-bit instruction reads to the memory port.
- Buffers one fetched instruction and hands it downstream over a valid/ready handshake.
- Accepts redirects (branch/jump target) from downstream and discards stale in-flight fetches.

Parameters:
- XLEN, 64, width of the PC and of redirect/address buses.
- RESET_PC, 64'h0000000080000000, PC value loaded on reset.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- mem_req_valid  output  1  fetch request valid.
- mem_req_ready  input  1  memory accepts request this cycle.
- mem_req_addr  output  XLEN  fetch address; always equals the current PC.
- mem_rsp_valid  input  1  read data valid; arrives at least 1 cycle after acceptance.
- mem_rsp_data  input  32  instruction word.
- inst_valid  output  1  output buffer holds an instruction.
- inst_ready  input  1  downstream consumes the instruction this cycle.
- inst_out  output  32  buffered instruction.
- inst_pc  output  XLEN  PC of inst_out.
- inst_fault  output  1  buffered entry is a misalignment fault (see Optional Feature).
- redirect_valid  input  1  replace the PC with redirect_pc.
- redirect_pc  input  XLEN  redirect target.

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_PC, state=IDLE, drop=0.
  - inst_valid=0, inst_out=0, inst_pc=0, inst_fault=0.
  - mem_req_valid=0 in the cycle rst is high; it may assert from the first cycle after.
  - Reset mid-transaction abandons any outstanding request. A response arriving after reset while state=IDLE is ignored.
- States:
  - IDLE: may issue a request.
  - WAIT: one request outstanding.
- Issue condition (IDLE only):
  - mem_req_valid = !rst && !redirect_valid && (!inst_valid || inst_ready).
  - mem_req_valid is combinational from these terms. It is not held stable across a redirect; the address retargets to the new PC.
- IDLE -> WAIT when mem_req_valid && mem_req_ready. At that edge the issued address is latched as req_pc.
- Only one request may be outstanding at a time. No new request is issued while in WAIT.
- WAIT -> IDLE on mem_rsp_valid:
  - If drop=0: inst_out <= mem_rsp_data, inst_pc <= req_pc, inst_valid <= 1, inst_fault <= 0, pc <= req_pc + 4.
  - If drop=1: data discarded, drop <= 0, buffer untouched.
- Output handshake:
  - inst_valid && inst_ready at posedge clears inst_valid, unless a response loads it in the same edge.
  - Outputs are stable while inst_valid && !inst_ready.
- Fetch latency: best case 2 cycles from request issue to inst_valid, with a 1-cycle memory response. Throughput is 1 instruction per (memory latency + 1) cycles.
- Redirect (highest priority) when redirect_valid is high at a posedge:
  - pc <= redirect_pc, inst_valid <= 0.
  - If state is WAIT, or a request is accepted in the same cycle, drop <= 1.
  - If a response arrives in the same cycle as the redirect, it is discarded and drop is not set.
  - The next request goes to redirect_pc in the following cycle.
- Back-to-back redirects: the last one wins. drop remains a single bit, which is sufficient because only one request is ever outstanding.
- PC arithmetic: modulo 2^XLEN; pc + 4 wraps 0xFFFF_FFFF_FFFF_FFFC -> 0.
- mem_rsp_valid in IDLE (spurious) is ignored.

Optional Feature:
- Macro: IFU_MISALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0] != 0 issues no memory request.
  - The next posedge loads the buffer with inst_valid=1, inst_fault=1, inst_out=0, inst_pc=redirect_pc.
  - pc is held until another redirect; fetch stalls until then.
  - inst_fault clears when the entry is consumed.
- Not defined:
  - redirect_pc[1:0] is forced to 2'b00.
  - inst_fault is tied to 0.

Test Plan:
- Reset then always-ready memory with 1-cycle response -> first request at addr 0x80000000; inst_valid in cycle 3 with inst_pc=0x80000000; next request at 0x80000004.
- inst_ready held low 5 cycles with inst_valid=1 -> mem_req_valid stays 0 and inst_out/inst_pc stay stable; inst_ready=1 -> request for the next PC issued in the same cycle.
- Redirect to 0x80001000 while WAIT; stale response 0xDEADBEEF arrives 2 cycles later -> response dropped; next fetch at 0x80001000, whose data appears on inst_out.
- Redirect and mem_rsp_valid in the same cycle -> response discarded, inst_valid=0, drop stays 0, next request at the redirect target.
- Redirect to 0xFFFFFFFFFFFFFFFC -> after fetch, next request address is 0x0.
- With IFU_MISALIGN_CHECK_EN, redirect to 0x80000002 -> no mem_req_valid; inst_valid=1, inst_fault=1, inst_pc=0x80000002. Without the macro, the same redirect fetches from 0x80000000.
